uart_port_regs: RTL and testbench
=================================

# uart_port_regs

Peripheral-side responder for the TramelBlaze port bus on the UART channel. It takes the one-hot read and write strobes produced by the address decoder for channel 0, together with processor OUT_PORT data. It holds the UART control, transmit and receive registers and returns read data on IN_PORT. It also raises and holds the processor INTERRUPT line until the processor acknowledges it.

## Interface
- No parameters; the register map is fixed.
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- READS  in  16  one-hot read strobe, channel 0.
- WRITES  in  16  one-hot write strobe, channel 0.
- OUT_PORT  in  16  processor write data.
- RX_DATA  in  8  received byte from the UART receive engine.
- RX_RDY  in  1  one-cycle pulse: RX_DATA is valid.
- TX_DONE  in  1  one-cycle pulse: transmit engine is finished with the byte.
- INTERRUPT_ACK  in  1  processor interrupt acknowledge.
- IN_PORT  out  16  read data, combinational from the current register state.
- TX_DATA  out  8  byte to transmit.
- TX_START  out  1  one-cycle pulse that starts a transmission.
- BAUD_SEL  out  4  baud-rate select.
- EIGHT  out  1  selects 8 data bits (0 selects 7 data bits).
- PEN  out  1  parity enable.
- OHEL  out  1  parity select: 1 = odd, 0 = even.
- INTERRUPT  out  1  level interrupt request to the processor.

## Operation
Register map, by strobe bit index:
- Bit 0, read: {8'h00, rx_buf}. Clears RXRDY.
- Bit 0, write: loads OUT_PORT[7:0] into TX_DATA, pulses TX_START and clears TXRDY.
  - Accepted only if the registered TXRDY is 1; otherwise the write is dropped and TX_START stays 0.
- Bit 1, read: status word. Bit 0 = RXRDY, bit 1 = TXRDY, bit 2 = OVF, bits 15:3 = 0. Clears OVF.
- Bit 2, read/write: control word.
  - Bits 3:0 = BAUD_SEL, bit 4 = EIGHT, bit 5 = PEN, bit 6 = OHEL, bit 7 = RXIE, bit 8 = TXIE.
  - Bits 15:9 are ignored on write and read back as 0.
- Any other read index returns 16'h0000; writes to other indices are ignored.
- More than one READS bit set (illegal): IN_PORT sources the lowest set index; clear-on-read side effects apply to every set bit.
- RX_RDY: loads rx_buf and sets RXRDY.
  - If RXRDY was already 1 and this cycle does not read bit 0, the buffer is overwritten and OVF is set.
- Simultaneous RX_RDY and a bit-0 read: new byte loaded, RXRDY stays 1, OVF unchanged.
- TX_DONE sets TXRDY.
- Simultaneous OVF set and status read: the set wins.
- Interrupt request sources:
  - RX_RDY while RXIE = 1.
  - TX_DONE while TXIE = 1.
  - Either source sets INTERRUPT on the next edge.
- Interrupt clearing:
  - INTERRUPT_ACK clears INTERRUPT on the next edge.
  - Simultaneous set and ACK: the set wins.
- Reset values:
  - INTERRUPT = 0, TX_START = 0, TX_DATA = 0.
  - Control register = 0, so BAUD_SEL = 0, EIGHT = 0, PEN = 0, OHEL = 0.
  - rx_buf = 0, RXRDY = 0, OVF = 0, TXRDY = 1.
- Reset asserted mid-transmit: TXRDY returns to 1 immediately and any TX_DONE pulse in flight is harmless.

## Timing
- IN_PORT has zero latency: it is valid in the same cycle as the READS bit.
- Clear-on-read takes effect at the rising edge ending the strobe cycle.
- Accepted TX write: TX_DATA and TX_START are registered and appear 1 cycle after the WRITES cycle. TX_START is high for exactly 1 cycle; TXRDY reads 0 from that cycle onward.
- Control writes are visible on BAUD_SEL, EIGHT, PEN and OHEL 1 cycle after the strobe.
- RX_RDY to RXRDY = 1, and to INTERRUPT = 1: 1 cycle.
- Back-to-back TX writes: the second write is dropped, because TXRDY is already 0 when it arrives.

## Structure
- Package uart_regs_pkg holds:
  - register index constants: RX_TX_IDX = 0, STATUS_IDX = 1, CTRL_IDX = 2;
  - status bit positions;
  - control field positions and widths.
- One sub-module, uart_irq_ctrl: the set/ack interrupt flop with set-wins priority.
- Everything else lives in uart_port_regs.

## Test plan
- Reset, then read bit 1 → IN_PORT = 16'h0002. Read bit 2 → 16'h0000. INTERRUPT = 0.
- Write 16'h01A5 to bit 2 → BAUD_SEL = 5, EIGHT = 0, PEN = 1, OHEL = 0, RXIE = 1. Read bit 2 back → 16'h01A5.
- Write 16'h0041 to bit 0 → TX_DATA = 8'h41, one-cycle TX_START, status = 16'h0000.
  - Second write of 16'h0042 before TX_DONE → no TX_START, TX_DATA stays 8'h41.
  - TX_DONE → status = 16'h0002.
- RXIE = 1, RX_RDY with RX_DATA = 8'h3C → status bit 0 = 1, INTERRUPT = 1 after 1 cycle.
  - Read bit 0 → 16'h003C, then RXRDY = 0.
  - INTERRUPT_ACK → INTERRUPT = 0.
- Two RX_RDY pulses (8'h11 then 8'h22) with no read → status = 16'h0007. Read bit 0 → 16'h0022. Status read clears OVF → 16'h0002.
- RX_RDY and INTERRUPT_ACK in the same cycle → INTERRUPT stays 1. Assert RESET_N low mid-sequence → every output returns to its reset value immediately.

Source files
------------

// File: rtl/uart_regs_pkg.sv
// Register map constants and control-word layout for the UART port-bus responder.
package uart_regs_pkg;

  localparam int RX_TX_IDX  = 0;
  localparam int STATUS_IDX = 1;
  localparam int CTRL_IDX   = 2;

  localparam int ST_RXRDY = 0;
  localparam int ST_TXRDY = 1;
  localparam int ST_OVF   = 2;

  localparam int CTRL_BAUD_LSB = 0;
  localparam int CTRL_BAUD_W   = 4;
  localparam int CTRL_EIGHT    = 4;
  localparam int CTRL_PEN      = 5;
  localparam int CTRL_OHEL     = 6;
  localparam int CTRL_RXIE     = 7;
  localparam int CTRL_TXIE     = 8;
  localparam int CTRL_W        = 9;

  // Field order mirrors the bit positions above (MSB first).
  typedef struct packed {
    logic                   txie;
    logic                   rxie;
    logic                   ohel;
    logic                   pen;
    logic                   eight;
    logic [CTRL_BAUD_W-1:0] baud_sel;
  } ctrl_t;

endpackage

// File: rtl/uart_irq_ctrl.sv
// Level interrupt request flop: set and hold until acknowledged; set beats ack.
module uart_irq_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic ack,
  output logic irq
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      irq <= 1'b0;
    else if (set)
      irq <= 1'b1;
    else if (ack)
      irq <= 1'b0;
  end

endmodule

// File: rtl/uart_port_regs.sv
// UART channel responder on the TramelBlaze port bus: control, TX and RX
// registers, status with clear-on-read, and the processor interrupt line.
module uart_port_regs
  import uart_regs_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] READS,
  input  logic [15:0] WRITES,
  input  logic [15:0] OUT_PORT,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_RDY,
  input  logic        TX_DONE,
  input  logic        INTERRUPT_ACK,
  output logic [15:0] IN_PORT,
  output logic [7:0]  TX_DATA,
  output logic        TX_START,
  output logic [3:0]  BAUD_SEL,
  output logic        EIGHT,
  output logic        PEN,
  output logic        OHEL,
  output logic        INTERRUPT
);

  ctrl_t       ctrl_q;
  logic [7:0]  rx_buf;
  logic        rxrdy;
  logic        txrdy;
  logic        ovf;
  logic        rd_rx;
  logic        rd_status;
  logic        tx_accept;
  logic        irq_set;
  logic        unused_bits;

  assign rd_rx     = READS[RX_TX_IDX];
  assign rd_status = READS[STATUS_IDX];
  assign tx_accept = WRITES[RX_TX_IDX] & txrdy;
  assign irq_set   = (RX_RDY & ctrl_q.rxie) | (TX_DONE & ctrl_q.txie);

  // Strobe bits with no register behind them, and write data above the control width.
  assign unused_bits = ^{READS[15:3], WRITES[15:3], WRITES[STATUS_IDX], OUT_PORT[15:CTRL_W]};

  // Lowest set strobe index selects the read source.
  always_comb begin
    IN_PORT = 16'h0000;
    if (READS[RX_TX_IDX])
      IN_PORT = {8'h00, rx_buf};
    else if (READS[STATUS_IDX]) begin
      IN_PORT[ST_RXRDY] = rxrdy;
      IN_PORT[ST_TXRDY] = txrdy;
      IN_PORT[ST_OVF]   = ovf;
    end
    else if (READS[CTRL_IDX])
      IN_PORT = {{(16-CTRL_W){1'b0}}, ctrl_q};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ctrl_q   <= '0;
      rx_buf   <= 8'h00;
      rxrdy    <= 1'b0;
      ovf      <= 1'b0;
      txrdy    <= 1'b1;
      TX_DATA  <= 8'h00;
      TX_START <= 1'b0;
    end else begin
      TX_START <= tx_accept;

      if (WRITES[CTRL_IDX])
        ctrl_q <= ctrl_t'(OUT_PORT[CTRL_W-1:0]);

      if (tx_accept) begin
        TX_DATA <= OUT_PORT[7:0];
        txrdy   <= 1'b0;
      end else if (TX_DONE)
        txrdy <= 1'b1;

      // A new byte keeps RXRDY set even when the old one is being read.
      if (RX_RDY) begin
        rx_buf <= RX_DATA;
        rxrdy  <= 1'b1;
      end else if (rd_rx)
        rxrdy <= 1'b0;

      if (RX_RDY && rxrdy && !rd_rx)
        ovf <= 1'b1;
      else if (rd_status)
        ovf <= 1'b0;
    end
  end

  assign BAUD_SEL = ctrl_q.baud_sel;
  assign EIGHT    = ctrl_q.eight;
  assign PEN      = ctrl_q.pen;
  assign OHEL     = ctrl_q.ohel;

  uart_irq_ctrl u_irq (
    .clk   (CLK),
    .rst_n (RESET_N),
    .set   (irq_set),
    .ack   (INTERRUPT_ACK),
    .irq   (INTERRUPT)
  );

endmodule

// File: tb/tb_uart_port_regs.sv
// Self-checking bench for uart_port_regs: directed scenarios plus a randomized
// run against a behavioural register model.
module tb_uart_port_regs;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [15:0] READS, WRITES, OUT_PORT;
  logic [7:0]  RX_DATA;
  logic        RX_RDY, TX_DONE, INTERRUPT_ACK;
  logic [15:0] IN_PORT;
  logic [7:0]  TX_DATA;
  logic        TX_START;
  logic [3:0]  BAUD_SEL;
  logic        EIGHT, PEN, OHEL, INTERRUPT;

  int n_checks = 0;
  int n_fail   = 0;

  uart_port_regs dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .READS         (READS),
    .WRITES        (WRITES),
    .OUT_PORT      (OUT_PORT),
    .RX_DATA       (RX_DATA),
    .RX_RDY        (RX_RDY),
    .TX_DONE       (TX_DONE),
    .INTERRUPT_ACK (INTERRUPT_ACK),
    .IN_PORT       (IN_PORT),
    .TX_DATA       (TX_DATA),
    .TX_START      (TX_START),
    .BAUD_SEL      (BAUD_SEL),
    .EIGHT         (EIGHT),
    .PEN           (PEN),
    .OHEL          (OHEL),
    .INTERRUPT     (INTERRUPT)
  );

  always #5 CLK = ~CLK;

  task automatic idle();
    READS = 16'h0; WRITES = 16'h0; OUT_PORT = 16'h0;
    RX_DATA = 8'h0; RX_RDY = 1'b0; TX_DONE = 1'b0; INTERRUPT_ACK = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic edge_();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    idle();
    RESET_N = 1'b0;
    #3;
    n_checks++;
    if ({TX_START, TX_DATA, BAUD_SEL, EIGHT, PEN, OHEL, INTERRUPT} !== 17'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {TX_START, TX_DATA, BAUD_SEL, EIGHT, PEN, OHEL, INTERRUPT});
    end
    edge_(); edge_();
    RESET_N = 1'b1;
    edge_();
    READS = 16'h0002; #2;
    n_checks++;
    if (IN_PORT !== 16'h0002) begin n_fail++; $display("FAIL reset_status: got %h want 0002", IN_PORT); end
    edge_();
    READS = 16'h0004; #2;
    n_checks++;
    if (IN_PORT !== 16'h0000) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0000", IN_PORT); end
    edge_(); idle();
  endtask

  task automatic test_ctrl();
    WRITES = 16'h0004; OUT_PORT = 16'hFFFF;
    edge_(); idle();
    READS = 16'h0004; #2;
    n_checks++;
    if (IN_PORT !== 16'h01FF) begin n_fail++; $display("FAIL ctrl_upper_masked: got %h want 01ff", IN_PORT); end
    n_checks++;
    if ({BAUD_SEL, EIGHT, PEN, OHEL} !== 7'h7F) begin n_fail++; $display("FAIL ctrl_all_ones: got %h want 7f", {BAUD_SEL, EIGHT, PEN, OHEL}); end
    edge_(); idle();
    WRITES = 16'h0004; OUT_PORT = 16'h01A5;
    edge_(); idle();
    n_checks++;
    if (BAUD_SEL !== 4'h5 || EIGHT !== 1'b0 || PEN !== 1'b1 || OHEL !== 1'b0) begin
      n_fail++; $display("FAIL ctrl_fields: got baud=%h eight=%b pen=%b ohel=%b want 5 0 1 0", BAUD_SEL, EIGHT, PEN, OHEL);
    end
    READS = 16'h0004; #2;
    n_checks++;
    if (IN_PORT !== 16'h01A5) begin n_fail++; $display("FAIL ctrl_readback: got %h want 01a5", IN_PORT); end
    edge_(); idle();
  endtask

  task automatic test_tx();
    WRITES = 16'h0001; OUT_PORT = 16'h0041;
    #2;
    n_checks++;
    if (TX_START !== 1'b0) begin n_fail++; $display("FAIL tx_start_early: got %b want 0", TX_START); end
    edge_(); idle();
    n_checks++;
    if (TX_START !== 1'b1 || TX_DATA !== 8'h41) begin
      n_fail++; $display("FAIL tx_launch: got start=%b data=%h want 1 41", TX_START, TX_DATA);
    end
    READS = 16'h0002; #2;
    n_checks++;
    if (IN_PORT !== 16'h0000) begin n_fail++; $display("FAIL tx_busy_status: got %h want 0000", IN_PORT); end
    edge_(); idle();
    n_checks++;
    if (TX_START !== 1'b0) begin n_fail++; $display("FAIL tx_start_width: got %b want 0", TX_START); end
    WRITES = 16'h0001; OUT_PORT = 16'h0042;
    edge_(); idle();
    n_checks++;
    if (TX_START !== 1'b0 || TX_DATA !== 8'h41) begin
      n_fail++; $display("FAIL tx_busy_drop: got start=%b data=%h want 0 41", TX_START, TX_DATA);
    end
    TX_DONE = 1'b1;
    edge_(); idle();
    READS = 16'h0002; #2;
    n_checks++;
    if (IN_PORT !== 16'h0002) begin n_fail++; $display("FAIL tx_done_status: got %h want 0002", IN_PORT); end
    n_checks++;
    if (INTERRUPT !== 1'b1) begin n_fail++; $display("FAIL tx_irq: got %b want 1", INTERRUPT); end
    edge_(); idle();
    INTERRUPT_ACK = 1'b1;
    edge_(); idle();
    n_checks++;
    if (INTERRUPT !== 1'b0) begin n_fail++; $display("FAIL tx_irq_ack: got %b want 0", INTERRUPT); end
  endtask

  task automatic test_rx_irq();
    RX_RDY = 1'b1; RX_DATA = 8'h3C;
    edge_(); idle();
    n_checks++;
    if (INTERRUPT !== 1'b1) begin n_fail++; $display("FAIL rx_irq: got %b want 1", INTERRUPT); end
    READS = 16'h0002; #2;
    n_checks++;
    if (IN_PORT !== 16'h0003) begin n_fail++; $display("FAIL rx_status: got %h want 0003", IN_PORT); end
    edge_(); idle();
    READS = 16'h0001; #2;
    n_checks++;
    if (IN_PORT !== 16'h003C) begin n_fail++; $display("FAIL rx_data: got %h want 003c", IN_PORT); end
    edge_(); idle();
    READS = 16'h0002; #2;
    n_checks++;
    if (IN_PORT !== 16'h0002) begin n_fail++; $display("FAIL rx_cleared: got %h want 0002", IN_PORT); end
    edge_(); idle();
    INTERRUPT_ACK = 1'b1;
    edge_(); idle();
    n_checks++;
    if (INTERRUPT !== 1'b0) begin n_fail++; $display("FAIL rx_irq_ack: got %b want 0", INTERRUPT); end
  endtask

  task automatic test_overflow();
    RX_RDY = 1'b1; RX_DATA = 8'h11;
    edge_();
    RX_DATA = 8'h22;
    edge_(); idle();
    READS = 16'h0002; #2;
    n_checks++;
    if (IN_PORT !== 16'h0007) begin n_fail++; $display("FAIL ovf_status: got %h want 0007", IN_PORT); end
    edge_(); idle();
    READS = 16'h0001; #2;
    n_checks++;
    if (IN_PORT !== 16'h0022) begin n_fail++; $display("FAIL ovf_data: got %h want 0022", IN_PORT); end
    edge_(); idle();
    READS = 16'h0002; #2;
    n_checks++;
    if (IN_PORT !== 16'h0002) begin n_fail++; $display("FAIL ovf_cleared: got %h want 0002", IN_PORT); end
    edge_(); idle();
    // Overflow set collides with a status read: the set must survive.
    RX_RDY = 1'b1; RX_DATA = 8'h55;
    edge_(); idle();
    RX_RDY = 1'b1; RX_DATA = 8'h66; READS = 16'h0002; #2;
    n_checks++;
    if (IN_PORT !== 16'h0003) begin n_fail++; $display("FAIL ovf_pre_collide: got %h want 0003", IN_PORT); end
    edge_(); idle();
    READS = 16'h0002; #2;
    n_checks++;
    if (IN_PORT !== 16'h0007) begin n_fail++; $display("FAIL ovf_set_wins: got %h want 0007", IN_PORT); end
    edge_(); idle();
    // New byte arriving during a data read: RXRDY stays, no overflow.
    RX_RDY = 1'b1; RX_DATA = 8'h77; READS = 16'h0001; #2;
    n_checks++;
    if (IN_PORT !== 16'h0066) begin n_fail++; $display("FAIL rx_read_collide_data: got %h want 0066", IN_PORT); end
    edge_(); idle();
    READS = 16'h0002; #2;
    n_checks++;
    if (IN_PORT !== 16'h0003) begin n_fail++; $display("FAIL rx_read_collide_status: got %h want 0003", IN_PORT); end
    edge_(); idle();
    READS = 16'h0001; #2;
    n_checks++;
    if (IN_PORT !== 16'h0077) begin n_fail++; $display("FAIL rx_read_collide_byte: got %h want 0077", IN_PORT); end
    edge_(); idle();
    INTERRUPT_ACK = 1'b1;
    edge_(); idle();
  endtask

  task automatic test_irq_priority();
    INTERRUPT_ACK = 1'b1;
    edge_(); idle();
    RX_RDY = 1'b1; RX_DATA = 8'h5A; INTERRUPT_ACK = 1'b1;
    edge_(); idle();
    n_checks++;
    if (INTERRUPT !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got %b want 1", INTERRUPT); end
    INTERRUPT_ACK = 1'b1; READS = 16'h0001;
    edge_(); idle();
    n_checks++;
    if (INTERRUPT !== 1'b0) begin n_fail++; $display("FAIL irq_ack_clear: got %b want 0", INTERRUPT); end
    WRITES = 16'h0004; OUT_PORT = 16'h0000;
    edge_(); idle();
    RX_RDY = 1'b1; RX_DATA = 8'h01; TX_DONE = 1'b1;
    edge_(); idle();
    n_checks++;
    if (INTERRUPT !== 1'b0) begin n_fail++; $display("FAIL irq_disabled: got %b want 0", INTERRUPT); end
    READS = 16'h0001;
    edge_(); idle();
  endtask

  task automatic test_reset_mid();
    WRITES = 16'h0004; OUT_PORT = 16'h01A5;
    edge_(); idle();
    WRITES = 16'h0001; OUT_PORT = 16'h0099; RX_RDY = 1'b1; RX_DATA = 8'hAB;
    edge_(); idle();
    n_checks++;
    if (TX_START !== 1'b1 || INTERRUPT !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre_reset: got start=%b irq=%b want 1 1", TX_START, INTERRUPT);
    end
    RESET_N = 1'b0; #1;
    n_checks++;
    if ({TX_START, TX_DATA, BAUD_SEL, EIGHT, PEN, OHEL, INTERRUPT} !== 17'h0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h want 0", {TX_START, TX_DATA, BAUD_SEL, EIGHT, PEN, OHEL, INTERRUPT});
    end
    READS = 16'h0002; #1;
    n_checks++;
    if (IN_PORT !== 16'h0002) begin n_fail++; $display("FAIL mid_reset_status: got %h want 0002", IN_PORT); end
    READS = 16'h0; TX_DONE = 1'b1;
    edge_(); idle();
    RESET_N = 1'b1;
    edge_();
    READS = 16'h0002; #2;
    n_checks++;
    if (IN_PORT !== 16'h0002 || INTERRUPT !== 1'b0) begin
      n_fail++; $display("FAIL mid_after_release: got status=%h irq=%b want 0002 0", IN_PORT, INTERRUPT);
    end
    edge_(); idle();
  endtask

  task automatic test_random();
    logic [7:0]  m_rx, m_txdata;
    logic        m_rxrdy, m_ovf, m_txrdy, m_txstart, m_irq;
    logic [8:0]  m_ctrl;
    logic [15:0] exp_rd;
    logic        n_ovf, n_rxrdy;
    idle();
    RESET_N = 1'b0; #2; RESET_N = 1'b1;
    edge_();
    m_rx = 8'h00; m_txdata = 8'h00; m_rxrdy = 1'b0; m_ovf = 1'b0;
    m_txrdy = 1'b1; m_txstart = 1'b0; m_irq = 1'b0; m_ctrl = 9'h000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      case ($urandom_range(0, 7))
        3:       READS = 16'h0001;
        4:       READS = 16'h0002;
        5:       READS = 16'h0004;
        6:       READS = 16'(1 << $urandom_range(3, 15));
        7:       READS = 16'($urandom);
        default: READS = 16'h0000;
      endcase
      case ($urandom_range(0, 6))
        4:       WRITES = 16'h0001;
        5:       WRITES = 16'h0004;
        6:       WRITES = 16'($urandom);
        default: WRITES = 16'h0000;
      endcase
      OUT_PORT      = 16'($urandom);
      RX_DATA       = 8'($urandom);
      RX_RDY        = ($urandom_range(0, 3) == 0);
      TX_DONE       = ($urandom_range(0, 5) == 0);
      INTERRUPT_ACK = ($urandom_range(0, 4) == 0);

      if (READS[0])      exp_rd = {8'h00, m_rx};
      else if (READS[1]) exp_rd = {13'h0, m_ovf, m_txrdy, m_rxrdy};
      else if (READS[2]) exp_rd = {7'h0, m_ctrl};
      else               exp_rd = 16'h0000;
      #2;
      n_checks++;
      if (IN_PORT !== exp_rd) begin
        n_fail++; $display("FAIL rand_in_port cyc %0d: got %h want %h (reads %h)", cyc, IN_PORT, exp_rd, READS);
      end

      n_ovf = m_ovf;
      if (READS[1]) n_ovf = 1'b0;
      if (RX_RDY && m_rxrdy && !READS[0]) n_ovf = 1'b1;
      n_rxrdy = RX_RDY ? 1'b1 : (READS[0] ? 1'b0 : m_rxrdy);
      if (RX_RDY) m_rx = RX_DATA;
      m_txstart = WRITES[0] && m_txrdy;
      if (m_txstart) begin m_txdata = OUT_PORT[7:0]; m_txrdy = 1'b0; end
      else if (TX_DONE) m_txrdy = 1'b1;
      if ((RX_RDY && m_ctrl[7]) || (TX_DONE && m_ctrl[8])) m_irq = 1'b1;
      else if (INTERRUPT_ACK) m_irq = 1'b0;
      if (WRITES[2]) m_ctrl = OUT_PORT[8:0];
      m_ovf = n_ovf; m_rxrdy = n_rxrdy;

      edge_();
      n_checks++;
      if (TX_START !== m_txstart || TX_DATA !== m_txdata) begin
        n_fail++; $display("FAIL rand_tx cyc %0d: got start=%b data=%h want %b %h", cyc, TX_START, TX_DATA, m_txstart, m_txdata);
      end
      n_checks++;
      if ({OHEL, PEN, EIGHT, BAUD_SEL} !== m_ctrl[6:0]) begin
        n_fail++; $display("FAIL rand_ctrl cyc %0d: got %h want %h", cyc, {OHEL, PEN, EIGHT, BAUD_SEL}, m_ctrl[6:0]);
      end
      n_checks++;
      if (INTERRUPT !== m_irq) begin
        n_fail++; $display("FAIL rand_irq cyc %0d: got %b want %b", cyc, INTERRUPT, m_irq);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_tx();
    test_rx_irq();
    test_overflow();
    test_irq_priority();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
